// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD     = 4;
  // A length byte of zero requests a full 256-word program.
  localparam int unsigned LEN_ZERO_MEANS_MAX = 256;

  typedef enum logic [2:0] {
    StLen,
    StBytes,
    StWrite,
    StChk,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts incoming bytes MSB-first into a word and flags the final byte of each word.
// word_o and word_done_o are combinational so the caller can capture the word on the
// same edge that accepts its last byte.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = imem_loader_pkg::BYTES_PER_WORD,
  parameter int unsigned DATA_W         = 8 * BYTES_PER_WORD
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic [7:0]        byte_i,
  input  logic              strobe_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_done_o
);

  localparam int unsigned CntW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  // Only the bytes already received are stored; the newest byte comes straight from byte_i.
  logic [DATA_W-9:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  assign word_o      = {shift_q, byte_i};
  assign word_done_o = strobe_i && (cnt_q == CntW'(BYTES_PER_WORD - 1));

  // Next-state for shift register and byte counter.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (strobe_i) begin
      shift_d = word_o[DATA_W-9:0];
      cnt_d   = word_done_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Assembly state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: length byte, then MSB-first payload words written to
// instruction memory from address 0; holds the CPU until the load completes.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned BYTES_PER_WORD = imem_loader_pkg::BYTES_PER_WORD,
  parameter int unsigned DATA_W         = 8 * BYTES_PER_WORD
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              error
);

  // One extra bit so a full 2**ADDR_W word count is representable.
  localparam int unsigned CntW = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;

  logic              rx_fire;
  logic              asm_strobe;
  logic              asm_clr;
  logic [DATA_W-1:0] asm_word;
  logic              asm_done;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
  logic              error_q, error_d;
`endif

  assign rx_fire    = rx_valid && rx_ready_q;
  assign asm_strobe = rx_fire && (state_q == StBytes);
  assign asm_clr    = (state_q == StLen);

  imem_loader_word_assembler #(
    .BYTES_PER_WORD(BYTES_PER_WORD),
    .DATA_W        (DATA_W)
  ) u_word_assembler (
    .clk_i      (clk100),
    .rst_ni     (rst_n),
    .clr_i      (asm_clr),
    .byte_i     (rx_data),
    .strobe_i   (asm_strobe),
    .word_o     (asm_word),
    .word_done_o(asm_done)
  );

  // State register.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLen;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath updates (word count, write address, captured word, checksum).
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      StLen: begin
        if (rx_fire) begin
          count_d   = (rx_data == 8'd0) ? CntW'(LEN_ZERO_MEANS_MAX) : CntW'(rx_data);
          wr_addr_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d     = '0;
`endif
          state_d   = StBytes;
        end
      end
      StBytes: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (rx_fire) xor_d = xor_q ^ rx_data;
`endif
        if (asm_done) begin
          wr_data_d = asm_word;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        count_d   = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StBytes;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (rx_fire) state_d = (rx_data == xor_q) ? StDone : StErr;
      end
      StErr: begin
        if (reload) begin
          state_d   = StLen;
          wr_addr_d = '0;
        end
      end
`endif
      StDone: begin
        if (reload) begin
          state_d   = StLen;
          wr_addr_d = '0;
        end
      end
      default: state_d = StLen;
    endcase
  end

  // Registered outputs follow the state being entered, so they line up with state_q.
  always_comb begin
    rx_ready_d = (state_d == StLen) || (state_d == StBytes) || (state_d == StChk);
    wr_en_d    = (state_d == StWrite);
    cpu_run_d  = (state_d == StDone);
    busy_d     = (state_d != StDone);
`ifdef IMEM_LOADER_CHECKSUM_EN
    error_d    = (state_d == StErr);
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rx_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      cpu_run_q  <= cpu_run_d;
      busy_q     <= busy_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
      error_q    <= error_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_run  = cpu_run_q;
  assign busy     = busy_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign error    = error_q;
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares every wr_en pulse.
module tb_imem_loader;

  logic        clk100 = 1'b0;
  logic        rst_n  = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_run;
  logic        busy;
  logic        error;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  logic [63:0] sb[$];
  logic [31:0] prog[$];

  imem_loader dut (
    .clk100  (clk100),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .reload  (reload),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_run (cpu_run),
    .busy    (busy),
    .error   (error)
  );

  always #5 clk100 = ~clk100;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every wr_en pulse must match the head of the scoreboard.
  always @(negedge clk100) begin
    if (wr_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h, expected none",
                 wr_addr, wr_data);
      end else begin
        chk("wr_addr_data", {24'h0, wr_addr, wr_data}, sb.pop_front());
      end
      n_writes++;
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      rx_valid = 1'b0;
      @(negedge clk100);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 64) begin
      @(negedge clk100);
      n++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_byte_timeout: rx_ready=%0b, expected 1 within 64 cycles", rx_ready);
    end
    @(negedge clk100);
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    chk(name, {19'h0, rx_ready, wr_en, wr_addr, wr_data, cpu_run, busy, error},
        {19'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0});
  endtask

  // Sends length byte plus prog[] words (and checksum when enabled); ends in DONE.
  task automatic run_load(input logic [7:0] len, input bit gap);
    int          n;
    logic [7:0]  csum;
    logic [31:0] w;
    n    = (len == 8'd0) ? 256 : int'(len);
    csum = 8'h00;
    send_byte(len, gap);
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      sb.push_back({24'h0, i[7:0], w});
      for (int b = 3; b >= 0; b--) begin
        send_byte(w[8*b +: 8], gap);
        csum = csum ^ w[8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum, gap);
`else
    chk("wr_latency", {62'h0, wr_en, cpu_run}, {62'h0, 1'b1, 1'b0});
    @(negedge clk100);
`endif
  endtask

  task automatic expect_done(input string name, input logic [7:0] exp_addr);
    chk({name, "_run"}, {60'h0, cpu_run, busy, rx_ready, error}, {60'h0, 4'b1000});
    chk({name, "_addr"}, {56'h0, wr_addr}, {56'h0, exp_addr});
    chk({name, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reload(input string name);
    reload = 1'b1;
    @(negedge clk100);
    reload = 1'b0;
    chk(name, {59'h0, cpu_run, busy, rx_ready, error, 1'b0}, {59'h0, 5'b01100});
    chk({name, "_addr"}, {56'h0, wr_addr}, 64'h0);
  endtask

  initial begin
    int w0;
    // Reset
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk100);
    rst_n = 1'b1;
    @(negedge clk100);
    check_reset_vals("idle_after_reset");

    // Single word
    prog = '{32'h03128005};
    run_load(8'h01, 1'b0);
    expect_done("one_word", 8'h01);

    // Three words with rx_valid toggling
    do_reload("reload1");
    prog = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
    run_load(8'h03, 1'b1);
    expect_done("three_words", 8'h03);

    // Full 256-word program
    do_reload("reload2");
    prog = {};
    for (int i = 0; i < 256; i++) prog.push_back({i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3});
    w0 = n_writes;
    run_load(8'h00, 1'b0);
    expect_done("full_256", 8'h00);
    chk("full_256_count", 64'(n_writes - w0), 64'd256);

    // Extra bytes in DONE are refused
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (3) @(negedge clk100);
    rx_valid = 1'b0;
    chk("done_refuse", {62'h0, rx_ready, cpu_run}, {62'h0, 2'b01});

    // Reload then new word at address 0
    do_reload("reload3");
    prog = '{32'hCAFEF00D};
    run_load(8'h01, 1'b0);
    expect_done("after_reload", 8'h01);

    // Reload pulsed mid-BYTES is ignored
    do_reload("reload4");
    sb.push_back({24'h0, 8'h00, 32'h5A5AA5A5});
    send_byte(8'h01, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5A, 1'b0);
    reload = 1'b1;
    @(negedge clk100);
    reload = 1'b0;
    chk("reload_ignored", {62'h0, busy, cpu_run}, {62'h0, 2'b10});
    send_byte(8'hA5, 1'b0);
    send_byte(8'hA5, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`else
    @(negedge clk100);
`endif
    expect_done("mid_bytes", 8'h01);

    // Reset in the middle of a word
    do_reload("reload5");
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst_n = 1'b0;
    #1 check_reset_vals("mid_load_reset");
    @(negedge clk100);
    rst_n = 1'b1;
    @(negedge clk100);
    prog = '{32'h0BADF00D};
    run_load(8'h01, 1'b0);
    expect_done("after_reset", 8'h01);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good checksum
    do_reload("reload6");
    prog = '{32'h11223344};
    run_load(8'h01, 1'b0);
    expect_done("csum_ok", 8'h01);
    // Bad checksum
    do_reload("reload7");
    sb.push_back({24'h0, 8'h00, 32'h11223344});
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h45, 1'b0);
    chk("csum_bad", {60'h0, cpu_run, busy, rx_ready, error}, {60'h0, 4'b0101});
    do_reload("csum_err_clear");
`endif

    repeat (2) @(negedge clk100);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream stage of the 8-bit processor. Receives a program as a byte stream (e.g. from a UART receiver), assembles 32-bit instruction words, and writes them into instruction memory at addresses 0..N-1.
- Holds the processor stalled until loading is complete, then asserts cpu_run.
- Processor PC/decode logic is gated by cpu_run, and the instruction-memory write port is driven by wr_*.

Parameters:
- ADDR_W, 8, instruction-memory address width (matches the 8-bit PC).
- DATA_W, 32, instruction word width.
- BYTES_PER_WORD, 4, bytes per word; DATA_W = 8*BYTES_PER_WORD.

Ports:
- clk100  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_ready  out  1  loader accepts a byte; a byte transfers when rx_valid && rx_ready.
- reload  in  1  single-cycle request to load a new program; honoured only in DONE.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write word.
- cpu_run  out  1  processor may execute; 0 holds the processor.
- busy  out  1  a load is in progress (state not DONE).
- error  out  1  sticky checksum error (only with CHECKSUM_EN; otherwise tied 0).

Interface decision: one clock (clk100); reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset values: state=LEN, rx_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_run=0, busy=1, error=0. All outputs are registered.
- Stream format: one length byte L, then 4*N payload bytes, where N=L and L=0 means 256 words. Bytes are MSB first: the first byte becomes wr_data[31:24].
- FSM states: LEN, BYTES, WRITE, (CHK), DONE, (ERR).
- LEN: rx_ready=1. On transfer, latch the word count, clear the byte counter, set wr_addr=0, go to BYTES.
- BYTES: rx_ready=1. Each transfer shifts the byte into the assembly register and increments the byte counter (0..3). On the 4th byte, go to WRITE.
- WRITE: one cycle.
  - wr_en=1 with wr_addr and wr_data stable; rx_ready=0.
  - Next cycle: wr_addr increments (wraps 255->0) and the word count decrements.
  - If the count reaches 0: go to DONE (or CHK with the feature). Otherwise return to BYTES.
- DONE: rx_ready=0, cpu_run=1, busy=0. Extra incoming bytes are not accepted.
- reload in DONE: next cycle cpu_run=0, busy=1, state=LEN, wr_addr=0. reload in any other state is ignored.
- rx_valid low stalls indefinitely with no timeout; the byte counter and address hold.
- Latency:
  - Last byte accepted to wr_en is 1 cycle.
  - Final wr_en to cpu_run is 1 cycle (no feature) or 1 cycle after the checksum byte is accepted (with feature).
- N=256: exactly 256 writes, addresses 0..255; wr_addr ends at 0.
- rst_n asserted mid-load: immediate return to reset values. Partially written memory contents are not cleared.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last word the FSM enters CHK, with rx_ready=1.
  - The next byte is compared against the running XOR of all payload bytes (the length byte is excluded).
  - Match: go to DONE.
  - Mismatch: go to ERR. In ERR, error=1, cpu_run=0, rx_ready=0, busy=1, until reset or reload; reload in ERR also clears error and goes to LEN.
- Disabled: no CHK or ERR state, no XOR register, error tied 0.

Decomposition:
- Shared package imem_loader_pkg:
  - State enumeration (LEN, BYTES, WRITE, CHK, DONE, ERR).
  - BYTES_PER_WORD.
  - Constant LEN_ZERO_MEANS_MAX=256.
- Natural sub-module word_assembler:
  - Shift register plus byte counter.
  - Inputs: byte and strobe. Outputs: word and word_done pulse.

Test Plan:
- L=0x01, bytes 0x03,0x12,0x80,0x05 -> one wr_en at addr 0 with wr_data 0x03128005; cpu_run=1 one cycle later; rx_ready=0.
- L=0x03 with rx_valid toggling every other cycle -> writes at addr 0,1,2 in order with correct words; no write during stalls; busy falls with cpu_run.
- L=0x00, 1024 payload bytes -> 256 writes covering addr 0..255; cpu_run=1; wr_addr wraps to 0.
- In DONE, pulse reload, then L=0x01 and 4 bytes -> cpu_run drops the next cycle and the new word is written at addr 0. Reload pulsed mid-BYTES is ignored.
- rst_n low after 2 of 4 bytes -> all outputs return to reset values immediately; a fresh stream loads correctly from addr 0.
- CHECKSUM_EN: L=0x01, bytes 0x11,0x22,0x33,0x44, checksum 0x44 -> DONE with cpu_run=1. Checksum 0x45 -> error=1, cpu_run=0; reload clears error.
